pci_initiator_ctrl: RTL and testbench
=====================================

Name: pci_initiator_ctrl

Overview:
PCI bus-master sequencer for one device on the shared bus. It turns a local "start" command (cmd, address, burst length) into a PCI transaction: req_n/gnt_n handshake with the bus arbiter, address phase, N data phases with irdy_n/trdy_n handshaking, and turnaround. It also detects master-abort (no devsel_n) and target stop. It sits between the device core and the arbiter-controlled PCI signals.

Parameters:
DATA_W, 32, AD bus / data width
LEN_W, 4, burst length counter width (max burst 2^LEN_W-1)
DEVSEL_TO, 5, data-phase cycles without devsel_n before master-abort

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse, begin transaction (ignored while busy)
cmd  in  4  PCI command; cmd[0]=1 write, 0 read
addr  in  DATA_W  start address
burst_len  in  LEN_W  number of data phases; 0 treated as 1
be_n  in  4  byte enables for data phases
wr_data  in  DATA_W  write word, held until data_ack
data_ack  out  1  pulse: one data phase completed
rd_data  out  DATA_W  read word, valid when data_ack and read
busy  out  1  high from start accepted until return to IDLE
done  out  1  one-cycle pulse at end of transaction
master_abort  out  1  status, valid with done
retry  out  1  status: stop_n with zero words moved, valid with done
req_n  out  1  bus request to arbiter, active-low
gnt_n  in  1  grant from arbiter, active-low
bus_frame_n  in  1  sampled FRAME# on bus
bus_irdy_n  in  1  sampled IRDY# on bus
frame_n  out  1  driven FRAME#
irdy_n  out  1  driven IRDY#
ctl_oe  out  1  enable for frame_n/irdy_n drivers
ad_out  out  DATA_W  driven AD
ad_in  in  DATA_W  sampled AD
ad_oe  out  1  AD driver enable
cbe_n  out  4  driven C/BE#
trdy_n  in  1  target ready, active-low
devsel_n  in  1  device select, active-low
stop_n  in  1  target stop, active-low

Behaviour:
- All outputs are registered; inputs are sampled at posedge clk.
- Reset (rst=1 at an edge): state IDLE; req_n=1, frame_n=1, irdy_n=1, ctl_oe=0, ad_oe=0, cbe_n=4'hF, ad_out=0, data_ack=0, done=0, busy=0, master_abort=0, retry=0, rd_data=0. Reset mid-transaction releases the bus at the next edge, with no done pulse.
- IDLE: start=1 latches cmd, addr, and remaining=max(burst_len,1); sets busy=1 and req_n=0; go to REQ.
- REQ: wait for gnt_n=0 && bus_frame_n=1 && bus_irdy_n=1 (bus idle). Then go to ADDR, driving ctl_oe=1, frame_n=0, ad_out=addr, ad_oe=1, cbe_n=cmd, req_n=1. If gnt_n is removed before the bus is taken, stay in REQ.
- ADDR (exactly 1 cycle): go to DATA, with irdy_n=0 and cbe_n=be_n.
  - Write: ad_out=wr_data, ad_oe=1.
  - Read: ad_oe=0 (turnaround).
  - Clear the devsel counter.
- DATA:
  - Transfer: the cycle where irdy_n=0 && trdy_n=0 is sampled.
  - On transfer: remaining-1, data_ack=1 next cycle; read latches rd_data=ad_in; write loads the next wr_data into ad_out.
  - frame_n=1 is driven during the final data phase (remaining==1), with irdy_n held 0.
  - Transfer with remaining==1: go to TURN.
  - stop_n=0 sampled: drive frame_n=1 (irdy_n stays 0) for one more cycle to complete the disconnect, then TURN. Set retry=1 if zero words were transferred.
  - devsel_n=1 for DEVSEL_TO consecutive DATA cycles: master_abort=1, frame_n=1, go to TURN.
  - Loss of gnt_n during DATA is ignored; the transaction continues.
- TURN (1 cycle): frame_n=1, irdy_n=1, ad_oe=0, cbe_n=4'hF. Next cycle: ctl_oe=0, done=1, busy=0; go to IDLE. Status outputs hold until the next start.
- start while busy is ignored. Simultaneous stop_n=0 with a final transfer counts the word and ends normally (retry=0).

Test Plan:
- Single write: start, cmd=4'h7, addr=32'h1000, len=1, gnt_n=0, devsel_n/trdy_n=0 in first DATA cycle -> req_n low 1 cycle; frame_n low exactly 1 cycle (ADDR); ad_out=32'h1000 then wr_data; one data_ack; done 2 cycles after transfer; master_abort=0.
- Read burst len=4, trdy_n=1 on the 2nd data cycle -> 4 data_ack pulses; rd_data matches ad_in each time; frame_n rises with the 4th phase; ad_oe=0 throughout DATA.
- No devsel: len=2, devsel_n held 1 -> frame_n released after 5 DATA cycles; done with master_abort=1; zero data_ack.
- Retry: stop_n=0, trdy_n=1 on the first data cycle -> done with retry=1 and no data_ack. Disconnect: stop_n=0 after 2 transfers of len=4 -> retry=0 and 2 acks.
- Grant delay: gnt_n=1 for 3 cycles, then bus_frame_n=0 for 2 more -> ADDR only when gnt_n=0 and the bus is idle; start pulse during busy ignored.
- rst asserted in DATA -> next edge all outputs at reset values; a new start then runs normally.

Source files
------------

// File: rtl/pci_initiator_ctrl.sv
// PCI bus-master sequencer: arbiter request, address phase, burst data phases,
// turnaround, with master-abort (no DEVSEL#) and target-stop handling.
module pci_initiator_ctrl #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int DEVSEL_TO = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cmd,
  input  logic [DATA_W-1:0] addr,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [3:0]        be_n,
  input  logic [DATA_W-1:0] wr_data,
  output logic              data_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              master_abort,
  output logic              retry,
  output logic              req_n,
  input  logic              gnt_n,
  input  logic              bus_frame_n,
  input  logic              bus_irdy_n,
  output logic              frame_n,
  output logic              irdy_n,
  output logic              ctl_oe,
  output logic [DATA_W-1:0] ad_out,
  input  logic [DATA_W-1:0] ad_in,
  output logic              ad_oe,
  output logic [3:0]        cbe_n,
  input  logic              trdy_n,
  input  logic              devsel_n,
  input  logic              stop_n
);

  localparam int CW = $clog2(DEVSEL_TO + 1);

  typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, STOP, TURN} state_t;

  state_t            state, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CW-1:0]     dsel_q, dsel_d;
  logic              moved_q, moved_d;

  logic              req_n_d, frame_n_d, irdy_n_d, ctl_oe_d, ad_oe_d;
  logic [DATA_W-1:0] ad_out_d, rd_data_d;
  logic [3:0]        cbe_n_d;
  logic              data_ack_d, busy_d, done_d, master_abort_d, retry_d;
  logic              xfer, is_wr, to_turn;

  always_comb begin
    state_d        = state;
    cmd_d          = cmd_q;
    addr_d         = addr_q;
    rem_d          = rem_q;
    dsel_d         = dsel_q;
    moved_d        = moved_q;
    req_n_d        = req_n;
    frame_n_d      = frame_n;
    irdy_n_d       = irdy_n;
    ctl_oe_d       = ctl_oe;
    ad_out_d       = ad_out;
    ad_oe_d        = ad_oe;
    cbe_n_d        = cbe_n;
    rd_data_d      = rd_data;
    busy_d         = busy;
    master_abort_d = master_abort;
    retry_d        = retry;
    data_ack_d     = 1'b0;
    done_d         = 1'b0;
    to_turn        = 1'b0;
    is_wr          = cmd_q[0];
    xfer           = !irdy_n && !trdy_n;

    case (state)
      IDLE: begin
        if (start) begin
          cmd_d          = cmd;
          addr_d         = addr;
          rem_d          = (burst_len == '0) ? LEN_W'(1) : burst_len;
          moved_d        = 1'b0;
          busy_d         = 1'b1;
          req_n_d        = 1'b0;
          master_abort_d = 1'b0;
          retry_d        = 1'b0;
          state_d        = REQ;
        end
      end
      REQ: begin
        if (!gnt_n && bus_frame_n && bus_irdy_n) begin
          ctl_oe_d  = 1'b1;
          frame_n_d = 1'b0;
          ad_out_d  = addr_q;
          ad_oe_d   = 1'b1;
          cbe_n_d   = cmd_q;
          req_n_d   = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        irdy_n_d = 1'b0;
        cbe_n_d  = be_n;
        ad_oe_d  = is_wr;
        if (is_wr) ad_out_d = wr_data;
        dsel_d   = '0;
        if (rem_q == LEN_W'(1)) frame_n_d = 1'b0 | 1'b1;
        state_d  = DATA;
      end
      DATA: begin
        if (xfer) begin
          rem_d      = rem_q - 1'b1;
          moved_d    = 1'b1;
          data_ack_d = 1'b1;
          cbe_n_d    = be_n;
          if (is_wr) ad_out_d = wr_data;
          else       rd_data_d = ad_in;
        end
        // A transfer on the final phase wins over a simultaneous stop.
        if (xfer && rem_q == LEN_W'(1)) begin
          to_turn = 1'b1;
        end else if (!stop_n) begin
          frame_n_d = 1'b1;
          retry_d   = !(moved_q || xfer);
          state_d   = STOP;
        end else begin
          if (xfer && rem_q == LEN_W'(2)) frame_n_d = 1'b1;
          if (devsel_n) begin
            if (dsel_q == CW'(DEVSEL_TO - 1)) begin
              master_abort_d = 1'b1;
              to_turn        = 1'b1;
            end else begin
              dsel_d = dsel_q + 1'b1;
            end
          end else begin
            dsel_d = '0;
          end
        end
      end
      STOP: to_turn = 1'b1;
      TURN: begin
        ctl_oe_d = 1'b0;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (to_turn) begin
      frame_n_d = 1'b1;
      irdy_n_d  = 1'b1;
      ad_oe_d   = 1'b0;
      cbe_n_d   = '1;
      state_d   = TURN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      dsel_q       <= '0;
      moved_q      <= 1'b0;
      req_n        <= 1'b1;
      frame_n      <= 1'b1;
      irdy_n       <= 1'b1;
      ctl_oe       <= 1'b0;
      ad_out       <= '0;
      ad_oe        <= 1'b0;
      cbe_n        <= '1;
      rd_data      <= '0;
      busy         <= 1'b0;
      master_abort <= 1'b0;
      retry        <= 1'b0;
      data_ack     <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      dsel_q       <= dsel_d;
      moved_q      <= moved_d;
      req_n        <= req_n_d;
      frame_n      <= frame_n_d;
      irdy_n       <= irdy_n_d;
      ctl_oe       <= ctl_oe_d;
      ad_out       <= ad_out_d;
      ad_oe        <= ad_oe_d;
      cbe_n        <= cbe_n_d;
      rd_data      <= rd_data_d;
      busy         <= busy_d;
      master_abort <= master_abort_d;
      retry        <= retry_d;
      data_ack     <= data_ack_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_pci_initiator_ctrl.sv
// Scoreboard bench for pci_initiator_ctrl: directed transactions push expected
// acks/completions; a monitor pops and compares when data_ack/done appear.
module tb_pci_initiator_ctrl;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  cmd, be_n, cbe_n;
  logic [31:0] addr, wr_data, rd_data, ad_out, ad_in;
  logic [3:0]  burst_len;
  logic        data_ack, busy, done, master_abort, retry, req_n, gnt_n;
  logic        bus_frame_n, bus_irdy_n, frame_n, irdy_n, ctl_oe, ad_oe;
  logic        trdy_n, devsel_n, stop_n;

  pci_initiator_ctrl #(.DATA_W(32), .LEN_W(4), .DEVSEL_TO(5)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr),
    .burst_len(burst_len), .be_n(be_n), .wr_data(wr_data),
    .data_ack(data_ack), .rd_data(rd_data), .busy(busy), .done(done),
    .master_abort(master_abort), .retry(retry), .req_n(req_n),
    .gnt_n(gnt_n), .bus_frame_n(bus_frame_n), .bus_irdy_n(bus_irdy_n),
    .frame_n(frame_n), .irdy_n(irdy_n), .ctl_oe(ctl_oe), .ad_out(ad_out),
    .ad_in(ad_in), .ad_oe(ad_oe), .cbe_n(cbe_n), .trdy_n(trdy_n),
    .devsel_n(devsel_n), .stop_n(stop_n)
  );

  always #5 clk = ~clk;

  typedef struct {logic rd; logic [31:0] val;} ack_t;
  typedef struct {logic ma; logic rt; int unsigned acks;} done_t;

  ack_t  ack_q[$];
  done_t done_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Per-data-cycle target behaviour, indexed by DUT data-phase cycle.
  logic        tr_s[16], dv_s[16], st_s[16];
  logic [31:0] ai_s[16];
  int          txn_id = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic new_script();
    for (int i = 0; i < 16; i++) begin
      tr_s[i] = 1'b1; dv_s[i] = 1'b0; st_s[i] = 1'b1; ai_s[i] = '0;
    end
    txn_id++;
  endtask

  task automatic push_ack(input logic rd, input logic [31:0] v);
    ack_t a;
    a.rd = rd; a.val = v;
    ack_q.push_back(a);
  endtask

  task automatic push_done(input logic ma, input logic rt, input int unsigned n);
    done_t d;
    d.ma = ma; d.rt = rt; d.acks = n;
    done_q.push_back(d);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_n"}, req_n, 1'b1);
    check({tag, "_frame_n"}, frame_n, 1'b1);
    check({tag, "_irdy_n"}, irdy_n, 1'b1);
    check({tag, "_ctl_oe"}, ctl_oe, 1'b0);
    check({tag, "_ad_oe"}, ad_oe, 1'b0);
    check({tag, "_cbe_n"}, cbe_n, 4'hF);
    check({tag, "_ad_out"}, ad_out, 32'h0);
    check({tag, "_data_ack"}, data_ack, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_master_abort"}, master_abort, 1'b0);
    check({tag, "_retry"}, retry, 1'b0);
    check({tag, "_rd_data"}, rd_data, 32'h0);
  endtask

  // Issues one transaction and watches bus-side timing until done.
  task automatic run(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [3:0] len, input logic [31:0] wd, input int gdly,
                     input int bbusy, input bit extra,
                     input int exp_req, input int exp_frame, input int exp_lat);
    int r = 0, req_cyc = 0, frame_cyc = 0, since = 0, oe_rd = 0, lat = -1;
    bit got_addr = 0, finished = 0;
    logic [31:0] addr_seen = '0, data_ad = '0;
    logic [3:0]  cmd_seen = '0, data_cbe = '0;
    logic        busy_at_done = 1'b1;
    @(negedge clk);
    cmd = c; addr = a; burst_len = len; wr_data = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (req_n === 1'b0) begin
        req_cyc++;
        gnt_n       = (r < gdly) ? 1'b1 : 1'b0;
        bus_frame_n = (r >= gdly && r < gdly + bbusy) ? 1'b0 : 1'b1;
        start       = (extra && r == 1);
        r++;
      end else begin
        gnt_n = 1'b1; bus_frame_n = 1'b1; start = 1'b0;
      end
      if (got_addr) begin
        since++;
        if (since == 1) begin data_ad = ad_out; data_cbe = cbe_n; end
      end
      if (frame_n === 1'b0) begin
        frame_cyc++;
        if (!got_addr) begin got_addr = 1; addr_seen = ad_out; cmd_seen = cbe_n; end
      end
      if (irdy_n === 1'b0 && !c[0] && ad_oe === 1'b1) oe_rd++;
      if (data_ack === 1'b1 && c[0]) wr_data = wr_data + 1;
      if (done === 1'b1) begin
        lat = since; busy_at_done = busy; finished = 1; break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_timeout"}, finished, 1'b1);
    check({tag, "_req_cycles"}, req_cyc, exp_req);
    check({tag, "_frame_cycles"}, frame_cyc, exp_frame);
    check({tag, "_addr_phase_ad"}, addr_seen, a);
    check({tag, "_addr_phase_cbe"}, cmd_seen, c);
    check({tag, "_data_cbe"}, data_cbe, be_n);
    if (c[0]) check({tag, "_first_data_ad"}, data_ad, wd);
    else      check({tag, "_read_ad_oe_cycles"}, oe_rd, 0);
    check({tag, "_done_latency"}, lat, exp_lat);
    check({tag, "_busy_at_done"}, busy_at_done, 1'b0);
  endtask

  // Target model: drives the scripted response for each data-phase cycle.
  initial begin
    int idx = 0, seen_txn = 0;
    trdy_n = 1'b1; devsel_n = 1'b1; stop_n = 1'b1; ad_in = '0;
    forever begin
      @(posedge clk); #1;
      if (seen_txn != txn_id) begin seen_txn = txn_id; idx = 0; end
      if (irdy_n === 1'b0 && idx < 16) begin
        trdy_n = tr_s[idx]; devsel_n = dv_s[idx]; stop_n = st_s[idx]; ad_in = ai_s[idx];
        idx++;
      end else begin
        trdy_n = 1'b1; devsel_n = 1'b1; stop_n = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT reports an ack or completion.
  initial begin
    int unsigned seen = 0;
    ack_t  a;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        seen = 0;
      end else begin
        if (data_ack === 1'b1) begin
          seen++;
          check("ack_expected", ack_q.size() != 0, 1'b1);
          if (ack_q.size() != 0) begin
            a = ack_q.pop_front();
            if (a.rd) check("rd_data", rd_data, a.val);
            else      check("wr_ad_out", ad_out, a.val);
          end
        end
        if (done === 1'b1) begin
          check("done_expected", done_q.size() != 0, 1'b1);
          if (done_q.size() != 0) begin
            d = done_q.pop_front();
            check("master_abort", master_abort, d.ma);
            check("retry", retry, d.rt);
            check("ack_count", seen, d.acks);
          end
          seen = 0;
        end
      end
    end
  end

  initial begin
    int irdy_seen;
    rst = 1'b1; start = 1'b0; cmd = '0; addr = '0; burst_len = '0; be_n = 4'h0;
    wr_data = '0; gnt_n = 1'b1; bus_frame_n = 1'b1; bus_irdy_n = 1'b1;
    new_script();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    rst = 1'b0;

    // Single write, immediate grant and transfer.
    new_script();
    tr_s[0] = 1'b0;
    be_n = 4'h0;
    push_ack(1'b0, 32'hDEAD_BEEF);
    push_done(1'b0, 1'b0, 1);
    run("wr1", 4'h7, 32'h0000_1000, 4'd1, 32'hDEAD_BEEF, 0, 0, 0, 1, 1, 3);

    // Read burst of 4 with one target wait state.
    new_script();
    tr_s[0] = 1'b0; tr_s[1] = 1'b1; tr_s[2] = 1'b0; tr_s[3] = 1'b0; tr_s[4] = 1'b0;
    ai_s[0] = 32'h1111_0001; ai_s[1] = 32'hBAD0_0002; ai_s[2] = 32'h3333_0003;
    ai_s[3] = 32'h4444_0004; ai_s[4] = 32'h5555_0005;
    be_n = 4'h3;
    push_ack(1'b1, 32'h1111_0001); push_ack(1'b1, 32'h3333_0003);
    push_ack(1'b1, 32'h4444_0004); push_ack(1'b1, 32'h5555_0005);
    push_done(1'b0, 1'b0, 4);
    run("rd4", 4'h6, 32'h0000_2040, 4'd4, 32'h0, 0, 0, 0, 1, 5, 7);

    // No target claims the cycle: master-abort after 5 data cycles.
    new_script();
    for (int i = 0; i < 16; i++) dv_s[i] = 1'b1;
    be_n = 4'h0;
    push_done(1'b1, 1'b0, 0);
    run("abort", 4'h6, 32'h0000_3000, 4'd2, 32'h0, 0, 0, 0, 1, 6, 7);

    // Retry: stop on the first data cycle with nothing moved.
    new_script();
    st_s[0] = 1'b0;
    push_done(1'b0, 1'b1, 0);
    run("retry", 4'h6, 32'h0000_4000, 4'd3, 32'h0, 0, 0, 0, 1, 2, 4);

    // Disconnect after two write transfers of a 4-word burst.
    new_script();
    tr_s[0] = 1'b0; tr_s[1] = 1'b0; st_s[2] = 1'b0;
    push_ack(1'b0, 32'hA5A5_0000); push_ack(1'b0, 32'hA5A5_0001);
    push_done(1'b0, 1'b0, 2);
    run("disc", 4'h7, 32'h0000_5000, 4'd4, 32'hA5A5_0000, 0, 0, 0, 1, 4, 6);

    // Grant delayed 3 cycles, bus busy 2 more, stray start while busy.
    new_script();
    tr_s[0] = 1'b0;
    push_ack(1'b0, 32'h0BAD_F00D);
    push_done(1'b0, 1'b0, 1);
    run("gdly", 4'h7, 32'h0000_6000, 4'd0, 32'h0BAD_F00D, 3, 2, 1, 6, 1, 3);
    repeat (3) @(negedge clk);
    check("stray_start_busy", busy, 1'b0);
    check("stray_start_req_n", req_n, 1'b1);

    // Reset asserted mid data phase.
    new_script();
    cmd = 4'h6; addr = 32'h0000_7000; burst_len = 4'd4; gnt_n = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    irdy_seen = 0;
    for (int cyc = 0; cyc < 50 && irdy_seen < 2; cyc++) begin
      if (irdy_n === 1'b0) irdy_seen++;
      if (irdy_seen < 2) @(negedge clk);
    end
    check("rst_reached_data", irdy_seen, 2);
    rst = 1'b1; gnt_n = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;

    // Normal transaction after the mid-transaction reset.
    new_script();
    tr_s[0] = 1'b0;
    be_n = 4'h0;
    push_ack(1'b0, 32'h600D_CAFE);
    push_done(1'b0, 1'b0, 1);
    run("post_rst", 4'h7, 32'h0000_8000, 4'd1, 32'h600D_CAFE, 0, 0, 0, 1, 1, 3);

    repeat (4) @(negedge clk);
    check("acks_left", ack_q.size(), 0);
    check("dones_left", done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
